// File: rtl/block_select_pkg.sv
// block_select_pkg
//
// Shared definitions for the block selection controller: FSM state
// encodings and the board coordinate widths. Imported by block_select_ctrl
// and select_timer.

package block_select_pkg;

    // Board coordinate widths (columns, rows).
    localparam int unsigned BLOCK_X_W = 5;
    localparam int unsigned BLOCK_Y_W = 3;

    // Selection FSM states. The encodings are fixed so that the state can be
    // decoded by downstream debug logic.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StIssue = 2'd2
    } sel_state_e;

    // Width of a counter that must reach Cycles-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/select_timer.sv
// select_timer
//
// Free-running cycle counter that measures how long a source selection has
// been armed. The counter clears on clear_i (priority), increments while
// enable_i is high and reports expired_o in the cycle where the count has
// reached TIMEOUT_CYC-1 while enabled.
//
// Parameters:
//   TIMEOUT_CYC  number of enabled cycles until expiry
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clear_i    restart the count from zero
//   enable_i   count this cycle
//   expired_o  count has reached TIMEOUT_CYC-1 while enabled (combinational)

module select_timer
    import block_select_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = cnt_width(TIMEOUT_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired_o = enable_i && (cnt_q == CntLast);

endmodule

// File: rtl/block_select_ctrl.sv
// block_select_ctrl
//
// Converts the mouse interface's one-cycle left-click pulse plus block
// coordinates into board-level move commands. The first valid click arms a
// source block (sel_*), the second valid click on a different block commits
// a move (move_*) that is held on a valid/ready handshake until the game
// logic accepts it.
//
// Optional feature: define SELECT_TIMEOUT_EN to auto-cancel a source
// selection that stays armed for TIMEOUT_CYC cycles (uses select_timer).
// Without the macro an armed selection persists until a click, a my_turn
// drop or reset.
//
// Parameters:
//   TIMEOUT_CYC        armed-selection lifetime in cycles (timeout build only)
//
// Ports:
//   clk_i              system clock
//   rst_i              synchronous active-high reset
//   interboard_rst_i   synchronous active-high reset from the peer board
//   l_click_i          one-cycle left-click pulse
//   mouse_inblock_i    cursor lies inside a valid block
//   mouse_block_x_i    cursor block column
//   mouse_block_y_i    cursor block row
//   my_turn_i          local player may move
//   move_ready_i       game logic accepts the pending move this cycle
//   sel_valid_o        a source block is armed (highlight)
//   sel_block_x_o      armed source column
//   sel_block_y_o      armed source row
//   move_valid_o       move command pending
//   move_src_x_o/_y_o  move source block
//   move_dst_x_o/_y_o  move destination block
//
// All outputs are registered.

module block_select_ctrl
    import block_select_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 interboard_rst_i,
    input  logic                 l_click_i,
    input  logic                 mouse_inblock_i,
    input  logic [BLOCK_X_W-1:0] mouse_block_x_i,
    input  logic [BLOCK_Y_W-1:0] mouse_block_y_i,
    input  logic                 my_turn_i,
    input  logic                 move_ready_i,
    output logic                 sel_valid_o,
    output logic [BLOCK_X_W-1:0] sel_block_x_o,
    output logic [BLOCK_Y_W-1:0] sel_block_y_o,
    output logic                 move_valid_o,
    output logic [BLOCK_X_W-1:0] move_src_x_o,
    output logic [BLOCK_Y_W-1:0] move_src_y_o,
    output logic [BLOCK_X_W-1:0] move_dst_x_o,
    output logic [BLOCK_Y_W-1:0] move_dst_y_o
);

    // A one-cycle expiry window needs at least two counter states.
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("block_select_ctrl: TIMEOUT_CYC must be at least 2");
    end

    sel_state_e           state_q;
    logic                 sel_valid_q;
    logic [BLOCK_X_W-1:0] sel_x_q;
    logic [BLOCK_Y_W-1:0] sel_y_q;
    logic                 move_valid_q;
    logic [BLOCK_X_W-1:0] src_x_q;
    logic [BLOCK_Y_W-1:0] src_y_q;
    logic [BLOCK_X_W-1:0] dst_x_q;
    logic [BLOCK_Y_W-1:0] dst_y_q;

    logic rst_any;
    logic click_valid;
    logic click_outside;
    logic same_block;
    logic timeout_hit;

    assign rst_any       = rst_i || interboard_rst_i;
    assign click_valid   = l_click_i && mouse_inblock_i && my_turn_i;
    assign click_outside = l_click_i && !mouse_inblock_i;
    assign same_block    = (mouse_block_x_i == sel_x_q) && (mouse_block_y_i == sel_y_q);

`ifdef SELECT_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    // Clear on the edge that enters ARMED so the first armed cycle sees 0.
    assign timer_clear  = (state_q == StIdle) && click_valid;
    assign timer_enable = (state_q == StArmed);

    select_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_select_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_any),
        .clear_i  (timer_clear),
        .enable_i (timer_enable),
        .expired_o(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_any) begin
            state_q      <= StIdle;
            sel_valid_q  <= 1'b0;
            sel_x_q      <= '0;
            sel_y_q      <= '0;
            move_valid_q <= 1'b0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (click_valid) begin
                        sel_x_q     <= mouse_block_x_i;
                        sel_y_q     <= mouse_block_y_i;
                        sel_valid_q <= 1'b1;
                        state_q     <= StArmed;
                    end
                end

                StArmed: begin
                    // Priority: turn loss, outside click, valid click, timeout.
                    // A valid click therefore beats a same-cycle timeout.
                    if (!my_turn_i || click_outside) begin
                        sel_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end else if (click_valid) begin
                        sel_valid_q <= 1'b0;
                        if (same_block) begin
                            state_q <= StIdle;
                        end else begin
                            src_x_q      <= sel_x_q;
                            src_y_q      <= sel_y_q;
                            dst_x_q      <= mouse_block_x_i;
                            dst_y_q      <= mouse_block_y_i;
                            move_valid_q <= 1'b1;
                            state_q      <= StIssue;
                        end
                    end else if (timeout_hit) begin
                        sel_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                StIssue: begin
                    // Committed move: clicks and turn changes are ignored until
                    // the game logic takes it.
                    if (move_ready_i) begin
                        move_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end

                default: begin
                    sel_valid_q  <= 1'b0;
                    move_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign sel_valid_o   = sel_valid_q;
    assign sel_block_x_o = sel_x_q;
    assign sel_block_y_o = sel_y_q;
    assign move_valid_o  = move_valid_q;
    assign move_src_x_o  = src_x_q;
    assign move_src_y_o  = src_y_q;
    assign move_dst_x_o  = dst_x_q;
    assign move_dst_y_o  = dst_y_q;

endmodule

// File: tb/tb_block_select_ctrl.sv
// Directed self-checking bench for block_select_ctrl. Timeout steps are
// compiled in only when SELECT_TIMEOUT_EN is defined (TIMEOUT_CYC = 16).

module tb_block_select_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       interboard_rst;
    logic       l_click;
    logic       mouse_inblock;
    logic [4:0] mouse_block_x;
    logic [2:0] mouse_block_y;
    logic       my_turn;
    logic       move_ready;
    logic       sel_valid;
    logic [4:0] sel_block_x;
    logic [2:0] sel_block_y;
    logic       move_valid;
    logic [4:0] move_src_x;
    logic [2:0] move_src_y;
    logic [4:0] move_dst_x;
    logic [2:0] move_dst_y;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    block_select_ctrl #(
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .interboard_rst_i(interboard_rst),
        .l_click_i       (l_click),
        .mouse_inblock_i (mouse_inblock),
        .mouse_block_x_i (mouse_block_x),
        .mouse_block_y_i (mouse_block_y),
        .my_turn_i       (my_turn),
        .move_ready_i    (move_ready),
        .sel_valid_o     (sel_valid),
        .sel_block_x_o   (sel_block_x),
        .sel_block_y_o   (sel_block_y),
        .move_valid_o    (move_valid),
        .move_src_x_o    (move_src_x),
        .move_src_y_o    (move_src_y),
        .move_dst_x_o    (move_dst_x),
        .move_dst_y_o    (move_dst_y)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare flags; coordinates only where the matching valid is expected.
    task automatic expect_out(input string tag, input logic sv, input logic [4:0] sx,
                              input logic [2:0] sy, input logic mv, input logic [4:0] srx,
                              input logic [2:0] sry, input logic [4:0] dx,
                              input logic [2:0] dy);
        cmp({tag, ".sel_valid"}, {7'd0, sel_valid}, {7'd0, sv});
        cmp({tag, ".move_valid"}, {7'd0, move_valid}, {7'd0, mv});
        if (sv) begin
            cmp({tag, ".sel_x"}, {3'd0, sel_block_x}, {3'd0, sx});
            cmp({tag, ".sel_y"}, {5'd0, sel_block_y}, {5'd0, sy});
        end
        if (mv) begin
            cmp({tag, ".src_x"}, {3'd0, move_src_x}, {3'd0, srx});
            cmp({tag, ".src_y"}, {5'd0, move_src_y}, {5'd0, sry});
            cmp({tag, ".dst_x"}, {3'd0, move_dst_x}, {3'd0, dx});
            cmp({tag, ".dst_y"}, {5'd0, move_dst_y}, {5'd0, dy});
        end
    endtask

    task automatic expect_zero(input string tag);
        cmp({tag, ".sel_valid"}, {7'd0, sel_valid}, 8'd0);
        cmp({tag, ".sel_x"}, {3'd0, sel_block_x}, 8'd0);
        cmp({tag, ".sel_y"}, {5'd0, sel_block_y}, 8'd0);
        cmp({tag, ".move_valid"}, {7'd0, move_valid}, 8'd0);
        cmp({tag, ".src_x"}, {3'd0, move_src_x}, 8'd0);
        cmp({tag, ".src_y"}, {5'd0, move_src_y}, 8'd0);
        cmp({tag, ".dst_x"}, {3'd0, move_dst_x}, 8'd0);
        cmp({tag, ".dst_y"}, {5'd0, move_dst_y}, 8'd0);
    endtask

    // Inputs change 1 time unit after an edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic click(input logic [4:0] x, input logic [2:0] y, input logic inb);
        l_click       = 1'b1;
        mouse_inblock = inb;
        mouse_block_x = x;
        mouse_block_y = y;
        step();
        l_click       = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        interboard_rst = 1'b0;
        l_click        = 1'b0;
        mouse_inblock  = 1'b0;
        mouse_block_x  = '0;
        mouse_block_y  = '0;
        my_turn        = 1'b1;
        move_ready     = 1'b0;
        step();
        step();
        expect_zero("reset");
        rst = 1'b0;

        // Select and move with back-pressure.
        click(3, 2, 1);
        expect_out("arm32", 1, 3, 2, 0, 0, 0, 0, 0);
        click(7, 5, 1);
        expect_out("move", 0, 0, 0, 1, 3, 2, 7, 5);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("hold", 0, 0, 0, 1, 3, 2, 7, 5);
        end
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        expect_out("accepted", 0, 0, 0, 0, 0, 0, 0, 0);

        // Stray ready with nothing pending, then confirm IDLE by arming again.
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        expect_out("stray_ready", 0, 0, 0, 0, 0, 0, 0, 0);
        click(1, 1, 1);
        expect_out("idle_rearm", 1, 1, 1, 0, 0, 0, 0, 0);
        click(1, 1, 1);
        expect_out("deselect11", 0, 0, 0, 0, 0, 0, 0, 0);

        // Deselect and outside cancel.
        click(4, 1, 1);
        expect_out("arm41", 1, 4, 1, 0, 0, 0, 0, 0);
        click(4, 1, 1);
        expect_out("deselect41", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("deselect41_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        click(4, 1, 1);
        click(9, 0, 0);
        expect_out("outside_cancel", 0, 0, 0, 0, 0, 0, 0, 0);
        click(9, 0, 0);
        expect_out("outside_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Turn gating.
        my_turn = 1'b0;
        click(1, 1, 1);
        expect_out("not_turn", 0, 0, 0, 0, 0, 0, 0, 0);
        my_turn = 1'b1;
        click(1, 1, 1);
        expect_out("arm11", 1, 1, 1, 0, 0, 0, 0, 0);
        my_turn = 1'b0;
        click(2, 2, 1);
        expect_out("turn_drop", 0, 0, 0, 0, 0, 0, 0, 0);
        my_turn = 1'b1;
        step();
        expect_out("turn_drop_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Clicks and turn loss ignored while a move is pending.
        click(0, 0, 1);
        click(9, 7, 1);
        expect_out("move00_97", 0, 0, 0, 1, 0, 0, 9, 7);
        click(5, 5, 1);
        expect_out("issue_click", 0, 0, 0, 1, 0, 0, 9, 7);
        my_turn = 1'b0;
        step();
        expect_out("issue_turn", 0, 0, 0, 1, 0, 0, 9, 7);
        my_turn    = 1'b1;
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        expect_out("issue_accept", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("issue_idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Peer reset while ARMED.
        click(2, 2, 1);
        expect_out("arm22", 1, 2, 2, 0, 0, 0, 0, 0);
        interboard_rst = 1'b1;
        step();
        interboard_rst = 1'b0;
        expect_zero("ibrst_armed");

        // Peer reset while ISSUE, no ready: move dropped.
        click(3, 3, 1);
        click(4, 4, 1);
        expect_out("move33_44", 0, 0, 0, 1, 3, 3, 4, 4);
        interboard_rst = 1'b1;
        step();
        interboard_rst = 1'b0;
        expect_zero("ibrst_issue");
        step();
        expect_zero("ibrst_issue_after");

        // Reset beats a same-cycle valid click.
        rst = 1'b1;
        click(6, 6, 1);
        rst = 1'b0;
        expect_zero("rst_vs_click");

`ifdef SELECT_TIMEOUT_EN
        // Timeout after 16 armed cycles.
        click(2, 3, 1);
        for (int i = 0; i < 15; i++) step();
        expect_out("to_before", 1, 2, 3, 0, 0, 0, 0, 0);
        step();
        expect_out("to_expired", 0, 0, 0, 0, 0, 0, 0, 0);

        // Click in the expiry cycle wins.
        click(2, 3, 1);
        for (int i = 0; i < 15; i++) step();
        click(6, 0, 1);
        expect_out("to_click_wins", 0, 0, 0, 1, 2, 3, 6, 0);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        expect_out("to_accept", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
